// File: rtl/mem_arbiter.sv
// Arbitrates a single byte-wide RAM port between instruction fetch and load/store,
// serialising each 1/2/4-byte access into one RAM byte per cycle.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_len,
  input  logic [31:0] mem_wdata,
  input  logic [7:0]  ram_din,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  output logic [7:0]  ram_dout,
  output logic        if_done,
  output logic [31:0] if_data,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        mem_busy
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [2:0]  n_q, n_d;
  logic        owner_mem_q, owner_mem_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic [31:0] ram_a_q, ram_a_d;
  logic        ram_wr_q, ram_wr_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic        if_done_q, if_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic        mem_done_q, mem_done_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        mem_busy_q, mem_busy_d;
  logic        stall_q;
  logic [7:0]  hold_q;
  logic [7:0]  byte_in_s;
  logic [31:0] merged_s;
  logic [31:0] result_s;
  logic [2:0]  k_next_s;
  logic        last_s;

  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      2'b00:   len_to_n = 3'd1;
      2'b01:   len_to_n = 3'd2;
      default: len_to_n = 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [2:0] idx);
    case (idx)
      3'd0:    get_byte = word[7:0];
      3'd1:    get_byte = word[15:8];
      3'd2:    get_byte = word[23:16];
      3'd3:    get_byte = word[31:24];
      default: get_byte = 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [2:0] idx,
                                           input logic [7:0] b);
    case (idx)
      3'd0:    put_byte = {word[31:8], b};
      3'd1:    put_byte = {word[31:16], b, word[7:0]};
      3'd2:    put_byte = {word[31:24], b, word[15:0]};
      3'd3:    put_byte = {b, word[23:0]};
      default: put_byte = word;
    endcase
  endfunction

  // The RAM keeps reacting to the held address while paused, so the byte that
  // belongs to the pre-pause address is parked in hold_q and used on resume.
  assign byte_in_s = stall_q ? hold_q : ram_din;
  assign merged_s  = put_byte(data_q, k_q - 3'd1, byte_in_s);
  assign result_s  = we_q ? data_q : merged_s;
  assign k_next_s  = k_q + 3'd1;
  assign last_s    = we_q ? (k_q == n_q - 3'd1) : (k_q == n_q);

  // Next-state and next-output computation, assuming the run enable is high.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    n_d         = n_q;
    owner_mem_d = owner_mem_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    ram_a_d     = ram_a_q;
    ram_wr_d    = 1'b0;
    ram_dout_d  = ram_dout_q;
    if_done_d   = 1'b0;
    if_data_d   = if_data_q;
    mem_done_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;
    mem_busy_d  = mem_busy_q;
    case (state_q)
      S_IDLE: begin
        k_d     = 3'd0;
        data_d  = 32'h0;
        ram_a_d = 32'h0;
        if (mem_req) begin
          state_d     = S_BUSY;
          owner_mem_d = 1'b1;
          we_d        = mem_we;
          n_d         = len_to_n(mem_len);
          addr_d      = mem_addr;
          wdata_d     = mem_wdata;
          ram_a_d     = mem_addr;
          ram_wr_d    = mem_we;
          ram_dout_d  = mem_wdata[7:0];
          mem_busy_d  = 1'b1;
        end else if (if_req) begin
          state_d     = S_BUSY;
          owner_mem_d = 1'b0;
          we_d        = 1'b0;
          n_d         = 3'd4;
          addr_d      = if_addr;
          wdata_d     = 32'h0;
          ram_a_d     = if_addr;
          mem_busy_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        data_d = (!we_q && (k_q != 3'd0)) ? merged_s : data_q;
        if (last_s) begin
          state_d    = S_DONE;
          ram_a_d    = 32'h0;
          ram_dout_d = 8'h00;
          if (owner_mem_q) begin
            mem_done_d  = 1'b1;
            mem_rdata_d = result_s;
          end else begin
            if_done_d = 1'b1;
            if_data_d = result_s;
          end
        end else begin
          k_d        = k_next_s;
          ram_a_d    = addr_q + {29'd0, k_next_s};
          ram_wr_d   = we_q;
          ram_dout_d = we_q ? get_byte(wdata_q, k_next_s) : ram_dout_q;
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        k_d         = 3'd0;
        ram_a_d     = 32'h0;
        if_data_d   = 32'h0;
        mem_rdata_d = 32'h0;
        mem_busy_d  = 1'b0;
      end
      default: begin
        state_d    = S_IDLE;
        k_d        = 3'd0;
        ram_a_d    = 32'h0;
        mem_busy_d = 1'b0;
      end
    endcase
  end

  // Architectural state and registered outputs; all of it freezes while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= 3'd0;
      n_q         <= 3'd0;
      owner_mem_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      data_q      <= 32'h0;
      ram_a_q     <= 32'h0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= 8'h00;
      if_done_q   <= 1'b0;
      if_data_q   <= 32'h0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= 32'h0;
      mem_busy_q  <= 1'b0;
    end else if (rdy) begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      owner_mem_q <= owner_mem_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      ram_a_q     <= ram_a_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
      if_done_q   <= if_done_d;
      if_data_q   <= if_data_d;
      mem_done_q  <= mem_done_d;
      mem_rdata_q <= mem_rdata_d;
      mem_busy_q  <= mem_busy_d;
    end
  end

  // Tracks pauses and parks the read byte seen in the first paused cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 1'b0;
      hold_q  <= 8'h00;
    end else begin
      stall_q <= ~rdy;
      if (!rdy && !stall_q) begin
        hold_q <= ram_din;
      end
    end
  end

  assign ram_a     = ram_a_q;
  assign ram_wr    = ram_wr_q & rdy;
  assign ram_dout  = ram_dout_q;
  assign if_done   = if_done_q & rdy;
  assign if_data   = if_data_q;
  assign mem_done  = mem_done_q & rdy;
  assign mem_rdata = mem_rdata_q;
  assign mem_busy  = mem_busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte RAM model, transaction-level reference memory,
// directed vector table, hand-written corner sequences and random traffic.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst, rdy, if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  mem_len;
  logic [7:0]  ram_din;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic        if_done, mem_done, mem_busy;
  logic [31:0] if_data, mem_rdata;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit        is_mem;
    bit        we;
    bit [1:0]  len;
    bit [31:0] addr;
    bit [31:0] wdata;
    int        stall_at;
    int        stall_n;
    int        exp_lat;
    bit        fixed;
    bit [31:0] exp_data;
  } vec_t;

  bit [7:0] ram_mem [bit [31:0]];
  bit [7:0] ref_mem [bit [31:0]];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_len(mem_len), .mem_wdata(mem_wdata),
    .ram_din(ram_din), .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout),
    .if_done(if_done), .if_data(if_data),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_busy(mem_busy)
  );

  function automatic bit [7:0] init_byte(input bit [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic bit [7:0] ref_rd(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic int nbytes(input bit [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  // Synchronous byte RAM: read data shows up one cycle after the address.
  always @(posedge clk) begin
    if (ram_wr === 1'b1) ram_mem[ram_a] = ram_dout;
    ram_din <= ram_mem.exists(ram_a) ? ram_mem[ram_a] : init_byte(ram_a);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input bit [31:0] a, input bit [7:0] b);
    ram_mem[a] = b;
    ref_mem[a] = b;
  endtask

  // Runs one transaction; entered and left at posedge+1 with the DUT idle.
  task automatic do_txn(input vec_t v, input bit scramble, input string name);
    int n, cyc, p, done_cyc, wr_cnt, addr_err, dout_err, busy_err, frz_err, other_err;
    bit we;
    bit [31:0] exp_d, got;
    n = v.is_mem ? nbytes(v.len) : 4;
    we = v.is_mem && v.we;
    exp_d = 32'h0;
    got = 32'h0;
    for (int i = 0; i < n; i++) begin
      bit [31:0] a;
      a = v.addr + 32'(i);
      if (we) ref_mem[a] = v.wdata[8*i +: 8];
      else exp_d[8*i +: 8] = ref_rd(a);
    end
    if (v.fixed) exp_d = v.exp_data;
    if (v.is_mem) begin
      mem_req = 1'b1; mem_we = v.we; mem_len = v.len; mem_addr = v.addr; mem_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    rdy = 1'b1;
    @(posedge clk); #1;
    p = 1; done_cyc = -1;
    wr_cnt = 0; addr_err = 0; dout_err = 0; busy_err = 0; frz_err = 0; other_err = 0;
    for (cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      rdy = !(cyc >= v.stall_at && cyc < v.stall_at + v.stall_n);
      #1;
      if (p <= n && ram_a !== v.addr + 32'(p - 1)) addr_err++;
      if (we && rdy && p <= n && ram_dout !== v.wdata[8*(p-1) +: 8]) dout_err++;
      if (ram_wr === 1'b1) wr_cnt++;
      if (!rdy && (ram_wr !== 1'b0 || if_done !== 1'b0 || mem_done !== 1'b0)) frz_err++;
      if (mem_busy !== v.is_mem) busy_err++;
      if ((v.is_mem ? if_done : mem_done) !== 1'b0) other_err++;
      if ((v.is_mem ? mem_done : if_done) === 1'b1) begin
        done_cyc = cyc;
        got = v.is_mem ? mem_rdata : if_data;
      end else begin
        if (scramble) begin
          mem_addr = $urandom; if_addr = $urandom; mem_wdata = $urandom;
          mem_len = 2'($urandom_range(0, 3)); mem_we = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        if (rdy) p++;
      end
    end
    check({name, "_latency"}, done_cyc, v.exp_lat);
    if (!we) check({name, "_data"}, got, exp_d);
    check({name, "_wr_count"}, wr_cnt, we ? n : 0);
    check({name, "_addr_dout"}, {addr_err, dout_err}, 64'd0);
    check({name, "_busy_frozen_other"}, {busy_err, frz_err, other_err}, 96'd0);
    if_req = 1'b0; mem_req = 1'b0; rdy = 1'b1;
    @(posedge clk); #2;
    check({name, "_idle"}, {ram_a, ram_wr, mem_busy, if_done, mem_done}, 36'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t vecs[12];
    vec_t r;
    int mem_cyc, if_cyc, busy_err, dcnt, n;
    bit [31:0] got_m, got_i;

    vecs[0]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0,          0, 0, 6, 1'b1, 32'h0000_0513};
    vecs[1]  = '{1'b1, 1'b1, 2'b10, 32'h0000_1000, 32'hDEAD_BEEF,  0, 0, 5, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 2'b10, 32'h0000_1000, 32'h0,          0, 0, 6, 1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 1'b0, 2'b10, 32'h0000_1000, 32'h0,          2, 3, 9, 1'b1, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0,          0, 0, 4, 1'b1, 32'h0000_1234};
    vecs[5]  = '{1'b1, 1'b1, 2'b00, 32'h0000_0010, 32'hFFFF_FF21,  0, 0, 2, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0010, 32'h0,          1, 3, 6, 1'b1, 32'h0000_0021};
    vecs[7]  = '{1'b1, 1'b0, 2'b01, 32'h0000_0010, 32'h0,          0, 0, 4, 1'b1, 32'h0000_4B21};
    vecs[8]  = '{1'b1, 1'b1, 2'b01, 32'h0000_0020, 32'hCAFE_BABE,  0, 0, 3, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 2'b11, 32'h0000_0020, 32'h0,          0, 0, 6, 1'b1, 32'h7978_BABE};
    vecs[10] = '{1'b1, 1'b1, 2'b10, 32'h0000_0030, 32'h0BAD_F00D,  2, 2, 7, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 2'b10, 32'h0000_0030, 32'h0,          4, 1, 7, 1'b1, 32'h0BAD_F00D};

    preload(32'h0000_0100, 8'h13); preload(32'h0000_0101, 8'h05);
    preload(32'h0000_0102, 8'h00); preload(32'h0000_0103, 8'h00);
    preload(32'hFFFF_FFFF, 8'h34); preload(32'h0000_0000, 8'h12);
    preload(32'h0000_2000, 8'hAB);
    preload(32'h0000_0300, 8'h93); preload(32'h0000_0301, 8'h00);
    preload(32'h0000_0302, 8'h10); preload(32'h0000_0303, 8'h00);

    rst = 1'b1; rdy = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    if_addr = 32'h0; mem_addr = 32'h0; mem_len = 2'b00; mem_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {ram_a, ram_wr, ram_dout, if_done, if_data, mem_done, mem_rdata, mem_busy}, 108'd0);
    rst = 1'b0; rdy = 1'b1;

    for (int i = 0; i < 12; i++) do_txn(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Simultaneous requests: MEM wins, IF waits through DONE and is granted from IDLE.
    if_req = 1'b1; if_addr = 32'h0000_0300;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h0000_2000;
    @(posedge clk); #1;
    mem_cyc = -1; if_cyc = -1; busy_err = 0; got_m = 32'h0; got_i = 32'h0;
    for (int c = 1; c <= 30 && if_cyc < 0; c++) begin
      #1;
      if (mem_busy !== ((mem_cyc < 0) ? 1'b1 : 1'b0)) busy_err++;
      if (mem_done === 1'b1) begin mem_cyc = c; got_m = mem_rdata; mem_req = 1'b0; end
      if (if_done === 1'b1) begin if_cyc = c; got_i = if_data; if_req = 1'b0; end
      @(posedge clk); #1;
    end
    check("arb_mem_cycle", mem_cyc, 3);
    check("arb_mem_rdata", got_m, 32'h0000_00AB);
    check("arb_if_cycle", if_cyc, 10);
    check("arb_if_data", got_i, 32'h0010_0093);
    check("arb_mem_busy", busy_err, 0);
    @(posedge clk); #1;

    // Reset in the middle of a word store: bytes 0 and 1 already reached the RAM.
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h0000_5000; mem_wdata = 32'h1122_3344;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_req = 1'b0;
    #1;
    check("rst_busy_outputs", {ram_a, ram_wr, ram_dout, if_done, if_data, mem_done, mem_rdata, mem_busy}, 108'd0);
    dcnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (if_done !== 1'b0 || mem_done !== 1'b0) dcnt++;
    end
    check("rst_no_done", dcnt, 0);
    ref_mem[32'h0000_5000] = 8'h44;
    ref_mem[32'h0000_5001] = 8'h33;
    r = '{1'b1, 1'b0, 2'b10, 32'h0000_5000, 32'h0, 0, 0, 6, 1'b1, 32'h0908_3344};
    do_txn(r, 1'b0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      r.is_mem = ($urandom_range(0, 2) != 0);
      r.we = r.is_mem && ($urandom_range(0, 1) == 1);
      r.len = 2'($urandom_range(0, 3));
      r.addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                            : 32'($urandom_range(0, 63));
      r.wdata = $urandom;
      n = r.is_mem ? nbytes(r.len) : 4;
      r.stall_n = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
      r.stall_at = $urandom_range(1, n);
      r.exp_lat = (r.we ? n + 1 : n + 2) + r.stall_n;
      r.fixed = 1'b0;
      r.exp_data = 32'h0;
      do_txn(r, 1'b1, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, rising edge.
REQ-002 SHALL have ports: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: rdy  input  1  global run enable; low = pause.
REQ-004 SHALL have ports: if_req  input  1  fetch request, held until if_done.
REQ-005 SHALL have ports: if_addr  input  32  fetch byte address.
REQ-006 SHALL have ports: mem_req  input  1  load/store request, held until mem_done.
REQ-007 SHALL have ports: mem_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have ports: mem_addr  input  32  load/store byte address.
REQ-009 SHALL have ports: mem_len  input  2  access size: 00 = byte, 01 = half, 10/11 = word.
REQ-010 SHALL have ports: mem_wdata  input  32  store data, little-endian, low bytes used.
REQ-011 SHALL have ports: ram_din  input  8  RAM read data, valid one cycle after address.
REQ-012 SHALL have ports: ram_a  output  32  RAM byte address.
REQ-013 SHALL have ports: ram_wr  output  1  RAM write strobe.
REQ-014 SHALL have ports: ram_dout  output  8  RAM write data.
REQ-015 SHALL have ports: if_done  output  1  one-cycle fetch completion pulse.
REQ-016 SHALL have ports: if_data  output  32  fetched word, valid while if_done = 1.
REQ-017 SHALL have ports: mem_done  output  1  one-cycle load/store completion pulse.
REQ-018 SHALL have ports: mem_rdata  output  32  zero-extended load data, valid while mem_done = 1.
REQ-019 SHALL have ports: mem_busy  output  1  high while a MEM transaction owns the RAM port.

Function
REQ-020 SHALL implement FSM states IDLE, BUSY, DONE; every state update is gated by rdy = 1.
REQ-021 IDLE: on mem_req = 1, SHALL latch mem_addr, mem_we, mem_len, mem_wdata with owner = MEM and go to BUSY; else on if_req = 1, SHALL latch if_addr with len = 4, owner = IF, read, and go to BUSY.
REQ-022 Simultaneous if_req and mem_req in IDLE SHALL grant MEM; IF waits.
REQ-023 Byte count N SHALL be 1/2/4 per len; byte counter k SHALL start at 0 on entry to BUSY.
REQ-024 BUSY read, cycle k: SHALL drive ram_a = addr + k for k < N; for k >= 1 SHALL capture ram_din into byte k-1 of the data register; after k = N go to DONE.
REQ-025 BUSY write, cycle k (k < N): SHALL drive ram_a = addr + k, ram_wr = 1, ram_dout = wdata[8k+7:8k]; after k = N-1 go to DONE.
REQ-026 ram_a arithmetic SHALL be 32-bit modulo 2^32 (0xFFFFFFFF + 1 = 0x00000000).
REQ-027 DONE: SHALL pulse the owner's done for exactly one cycle with data on if_data or mem_rdata, and return to IDLE unconditionally; a req still high during DONE SHALL NOT be re-granted until IDLE.
REQ-028 Latency: word read: done asserted 6 cycles after the grant edge (BUSY 5 cycles); word write: done 5 cycles after the grant edge.
REQ-029 Requests are latched; changes to request inputs during BUSY/DONE SHALL be ignored.
REQ-030 ram_wr SHALL be 0 outside BUSY-write and whenever rdy = 0.
REQ-031 rdy = 0 SHALL freeze state, counter and registers and hold ram_a; done pulses SHALL NOT fire while rdy = 0.
REQ-032 mem_busy SHALL be 1 in BUSY and DONE when owner = MEM, else 0.
REQ-033 In IDLE, ram_a SHALL be 0 and ram_wr 0.

Reset
REQ-034 rst = 1 at a clock edge SHALL force IDLE, k = 0, all outputs and data registers 0, overriding rdy.
REQ-035 rst during BUSY SHALL abandon the transaction with no done pulse; any partial write is not undone.

Verification
REQ-036 IF fetch of 0x00000100, RAM bytes 13,05,00,00 -> ram_a 0x100..0x103, if_done with if_data = 0x00000513 at cycle 6.
REQ-037 if_req and mem_req (load byte 0x2000 = 0xAB) in the same cycle -> MEM served first, mem_rdata = 0x000000AB; IF served after, mem_busy low during IF.
REQ-038 Store word 0xDEADBEEF to 0x1000 -> ram_wr for 4 cycles, ram_dout EF,BE,AD,DE at 0x1000..0x1003, mem_done in the fifth cycle.
REQ-039 Halfword load at 0xFFFFFFFF -> ram_a 0xFFFFFFFF then 0x00000000, mem_rdata zero-extended 16 bits.
REQ-040 rdy low for 3 cycles mid-word-read -> result identical, done delayed exactly 3 cycles, ram_wr stays 0.
REQ-041 rst asserted during BUSY write -> next cycle IDLE, all outputs 0, no done pulse; a new request then completes normally.
